// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequences FETCH -> WAIT -> ISSUE against a one-cycle-latency
// instruction memory, holds the latched word until the execute stage acknowledges it.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  // Branch targets are forced to word alignment, so the low target bits never matter.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; reset is synchronous and also clears the instruction latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        instr_d = imem_rdata;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // redirect is only meaningful alongside the acknowledge.
        if (instr_ack) begin
          if (instr_q[31:26] == HALT_OPCODE) begin
            state_d = S_HALT;
          end else begin
            pc_d    = redirect ? {redirect_pc[31:2], 2'b00} : pc_q + 32'd4;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_en     = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign func        = instr_q[4:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr_valid = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a transaction-level model compared every cycle,
// plus directed scenarios with literal expectations (sequential, branch, stall, halt, wrap, reset).
module tb_instr_fetch_unit;

  localparam logic [5:0] HALT_OP = 6'b111111;

  logic        clk = 1'b0;
  logic        rst, start, instr_ack, redirect;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_en, instr_valid, halted;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [5:0]  opcode;
  logic [4:0]  func;

  // Second instance exercising the top-of-address-space wrap.
  logic        w_start, w_ack, w_en, w_valid, w_halted;
  logic [31:0] w_rdata, w_addr, w_instr, w_pc, w_pc_plus4;
  logic [5:0]  w_opcode;
  logic [4:0]  w_func;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode), .func(func), .pc(pc),
    .pc_plus4(pc_plus4), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .start(w_start), .imem_en(w_en), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .instr(w_instr), .opcode(w_opcode), .func(w_func), .pc(w_pc),
    .pc_plus4(w_pc_plus4), .instr_valid(w_valid), .instr_ack(w_ack),
    .redirect(1'b0), .redirect_pc(32'h0), .halted(w_halted)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Instruction memory shared by the memory responder and the model.
  logic [31:0] mem [256];

  always @(posedge clk) begin
    cycle++;
    if (imem_en) imem_rdata <= mem[imem_addr[9:2]];
    if (w_en)    w_rdata    <= 32'h0400_0000;
  end

  // Transaction-level model: an instruction is fetched, arrives two cycles later,
  // and is offered until acknowledged; the acknowledge picks the next address.
  logic        m_ok = 1'b0;
  logic        m_active, m_halted;
  int          m_age;
  logic [31:0] m_pc, m_instr;

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; m_active = 1'b0; m_halted = 1'b0; m_age = 0;
      m_pc = 32'h0; m_instr = 32'h0;
    end else if (m_ok && !m_halted) begin
      if (!m_active) begin
        if (start) begin m_active = 1'b1; m_age = 0; end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (m_age == 1) begin
        m_instr = mem[m_pc[9:2]];
        m_age = 2;
      end else if (instr_ack) begin
        if (m_instr[31:26] == HALT_OP) begin
          m_halted = 1'b1; m_active = 1'b0;
        end else begin
          m_pc  = redirect ? (redirect_pc & 32'hFFFF_FFFC) : m_pc + 32'd4;
          m_age = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("m_imem_en",   imem_en,     m_active && m_age == 0);
      check("m_instr_vld", instr_valid, m_active && m_age >= 2);
      check("m_halted",    halted,      m_halted);
      check("m_imem_addr", imem_addr,   m_pc);
      check("m_pc",        pc,          m_pc);
      check("m_pc_plus4",  pc_plus4,    m_pc + 32'd4);
      check("m_instr",     instr,       m_instr);
      check("m_opcode",    opcode,      m_instr[31:26]);
      check("m_func",      func,        m_instr[4:0]);
    end
  end

  task automatic wait_valid(output int when);
    int n = 0;
    while (!instr_valid && n < 20) begin @(negedge clk); n++; end
    check("valid_timeout", instr_valid, 1'b1);
    when = cycle;
  endtask

  task automatic ack_now(input logic r, input logic [31:0] target);
    instr_ack = 1'b1; redirect = r; redirect_pc = target;
    @(negedge clk);
    instr_ack = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int t0, t1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    mem[0]  = 32'h0400_0000;
    mem[1]  = 32'h0400_0001;
    mem[2]  = 32'h0800_0005;
    mem[64] = 32'h0C00_001F;  // 0x100, branch target
    mem[65] = 32'h1000_0002;  // 0x104
    mem[66] = 32'hFC00_0000;  // 0x108, halt
    rst = 1'b1; start = 1'b0; instr_ack = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    w_start = 1'b0; w_ack = 1'b0; imem_rdata = 32'h0; w_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_addr",    imem_addr, 32'h0);
    check("rst_pc4",     pc_plus4,  32'h4);
    check("rst_valid",   instr_valid, 1'b0);
    check("rst_en",      imem_en,   1'b0);
    check("rst_halted",  halted,    1'b0);
    check("rst_instr",   instr,     32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Sequential fetch with ack on the first issue cycle.
    pulse_start();
    wait_valid(t0);
    check("seq0_pc",   pc,     32'h0);
    check("seq0_op",   opcode, 6'b000001);
    check("seq0_func", func,   5'b00000);
    ack_now(1'b0, 32'h0);
    wait_valid(t1);
    check("seq1_pc",     pc,      32'h4);
    check("seq1_op",     opcode,  6'b000001);
    check("seq1_func",   func,    5'b00001);
    check("seq_period",  t1 - t0, 3);
    ack_now(1'b0, 32'h0);

    // Branch redirect from pc 0x8 with a misaligned target.
    wait_valid(t0);
    check("br_src_pc", pc, 32'h8);
    ack_now(1'b1, 32'h0000_0103);
    check("br_en",   imem_en,   1'b1);
    check("br_addr", imem_addr, 32'h100);
    wait_valid(t0);
    check("br_pc", pc, 32'h100);

    // Stall: no ack for 5 cycles while redirect toggles.
    for (int i = 0; i < 5; i++) begin
      redirect = i[0]; redirect_pc = 32'h0000_0200;
      @(negedge clk);
    end
    check("stall_instr", instr, 32'h0C00_001F);
    check("stall_valid", instr_valid, 1'b1);
    ack_now(1'b0, 32'h0000_0200);
    wait_valid(t0);
    check("stall_next_pc", pc, 32'h104);
    ack_now(1'b0, 32'h0);

    // Halt, then start pulses are ignored.
    wait_valid(t0);
    check("halt_op", opcode, 6'b111111);
    ack_now(1'b0, 32'h0);
    check("halt_set", halted, 1'b1);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      @(negedge clk);
    end
    start = 1'b0;
    check("halt_hold", halted,  1'b1);
    check("halt_en",   imem_en, 1'b0);

    // Reset leaves HALT.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("halt_rst", halted, 1'b0);
    @(negedge clk);

    // Reset while the memory word is in flight.
    mem[0] = 32'hDEAD_BEEF;
    pulse_start();            // now in FETCH
    @(negedge clk);           // now in WAIT, rdata carries 0xDEADBEEF
    check("mid_rdata", imem_rdata, 32'hDEAD_BEEF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_instr", instr,       32'h0);
    check("mid_valid", instr_valid, 1'b0);
    check("mid_pc",    pc,          32'h0);
    repeat (3) @(negedge clk);
    check("mid_idle_en", imem_en, 1'b0);

    // Wrap-around on the second instance.
    check("wrap_rst_addr", w_addr,     32'hFFFF_FFFC);
    check("wrap_rst_pc4",  w_pc_plus4, 32'h0);
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    begin
      int n = 0;
      while (!w_valid && n < 20) begin @(negedge clk); n++; end
    end
    check("wrap_valid", w_valid,    1'b1);
    check("wrap_pc",    w_pc,       32'hFFFF_FFFC);
    check("wrap_pc4",   w_pc_plus4, 32'h0);
    w_ack = 1'b1;
    @(negedge clk);
    w_ack = 1'b0;
    check("wrap_en",   w_en,   1'b1);
    check("wrap_addr", w_addr, 32'h0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 Parameter HALT_OPCODE, default 6'b111111: opcode that stops fetching.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that begins fetching from IDLE.
REQ-006 imem_en  output  1  instruction-memory read enable.
REQ-007 imem_addr  output  32  instruction-memory byte address, word aligned.
REQ-008 imem_rdata  input  32  instruction word, valid one cycle after the imem_en cycle.
REQ-009 instr  output  32  latched instruction word.
REQ-010 opcode  output  6  instr[31:26], feeding the control unit.
REQ-011 func  output  5  instr[4:0], feeding the control unit.
REQ-012 pc  output  32  address of the latched instruction.
REQ-013 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-014 instr_valid  output  1  instr, opcode, func and pc are valid for execution.
REQ-015 instr_ack  input  1  execute stage has consumed the current instruction.
REQ-016 redirect  input  1  taken branch or jump; sampled only with instr_ack.
REQ-017 redirect_pc  input  32  branch or jump target.
REQ-018 halted  output  1  halt opcode reached; fetching stopped.

Function
REQ-019 The FSM SHALL have the states IDLE, FETCH, WAIT, ISSUE and HALT.
REQ-020 IDLE: start=1 -> FETCH; otherwise remain in IDLE with the PC held.
REQ-021 FETCH: imem_en=1 and imem_addr=PC for exactly one cycle, then go to WAIT.
REQ-022 WAIT: latch imem_rdata into instr, then go to ISSUE.
REQ-023 ISSUE: instr_valid=1, with all instruction outputs held stable until instr_ack=1.
REQ-024 ISSUE with instr_ack=1 and opcode=HALT_OPCODE -> HALT, with the PC not updated.
REQ-025 ISSUE with instr_ack=1 and redirect=1 -> PC := {redirect_pc[31:2],2'b00}, then FETCH.
REQ-026 ISSUE with instr_ack=1 and redirect=0 -> PC := PC+4, wrapping 32'hFFFFFFFC to 32'h00000000, then FETCH.
REQ-027 redirect while instr_ack=0 SHALL be ignored, and instr_ack outside ISSUE SHALL be ignored.
REQ-028 instr_valid SHALL drop in the cycle after the acknowledging edge, so the minimum fetch-to-issue latency is 2 cycles and the minimum per-instruction period is 3 cycles.
REQ-029 HALT: halted=1, imem_en=0, instr_valid=0, and only rst exits this state.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 imem_en SHALL be 0 in every state except FETCH.
REQ-032 opcode and func SHALL be combinational slices of the latched instr register, not of imem_rdata.

Reset
REQ-033 rst=1 SHALL set state=IDLE, PC=RESET_PC, instr=0, instr_valid=0, imem_en=0 and halted=0 on the next edge.
REQ-034 imem_addr SHALL equal RESET_PC and pc_plus4 SHALL equal RESET_PC+4 while in reset.
REQ-035 rst SHALL take priority over every other input.
REQ-036 rst asserted in WAIT SHALL discard the returning imem_rdata, leaving instr=0.
REQ-037 rst asserted in HALT SHALL clear halted and return the FSM to IDLE.

Verification
REQ-038 Sequential fetch: reset, start, memory words 0x04000000 and 0x04000001, ack each one cycle after instr_valid -> pc 0x0 then 0x4, opcode 6'b000001, func 5'b00000 then 5'b00001, issue-to-issue period of 3 cycles.
REQ-039 Branch redirect: at pc=0x8, ack with redirect=1 and redirect_pc=0x00000103 -> next imem_addr=0x00000100, and pc=0x00000100 at the next instr_valid.
REQ-040 Stall and ignore: hold instr_ack=0 for 5 cycles in ISSUE while toggling redirect -> outputs stable, no imem_en pulse, and PC+4 used after the final ack with redirect=0.
REQ-041 Halt: fetch 0xFC000000 and ack -> halted=1 next cycle, imem_en stays 0 for 10 cycles, and start has no effect.
REQ-042 Wrap-around: RESET_PC=32'hFFFFFFFC, ack with no redirect -> next imem_addr=0x00000000, and pc_plus4 of the first instruction = 0x00000000.
REQ-043 Reset mid-fetch: assert rst in WAIT with imem_rdata=0xDEADBEEF -> instr=0, instr_valid=0, state IDLE, and PC=RESET_PC.
